// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: interrupt synchronizer, event priority, mstatus/mtvec/mepc/mcause
// and a RUN/HANDLER FSM that redirects the PC on traps and mret.
module trap_ctrl #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0008,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [31:0] pc_cur,
  input  logic        ill_instr,
  input  logic        ecall,
  input  logic        mret,
  input  logic        ext_int,
  input  logic        csr_we,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        trap_redirect,
  output logic [31:0] trap_pc,
  output logic        kill,
  output logic        int_ack,
  output logic        in_handler
);

  // Handshake: no valid/ready pairs here; step qualifies every event, and
  // trap_redirect/kill/int_ack are single-cycle combinational strobes.
  typedef enum logic {RUN = 1'b0, HANDLER = 1'b1} state_t;

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_prev_q;
  logic                   int_pending_q, int_pending_d;
  logic                   mie_q, mie_d, mpie_q, mpie_d;
  logic [31:0]            mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;

  logic        active, in_run, int_rise;
  logic        take_int, take_exc, take_trap, take_mret, csr_wr;
  logic [31:0] cause;

  assign in_run   = (state_q == RUN);
  assign active   = step & rst_n;
  assign int_rise = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

  assign take_int  = active & int_pending_q & mie_q & in_run;
  assign take_exc  = active & ~take_int & (ill_instr | ecall | (mret & in_run));
  assign take_trap = take_int | take_exc;
  assign take_mret = active & ~take_trap & mret & ~in_run;
  assign csr_wr    = active & csr_we & ~take_trap & ~take_mret;

  // mret in RUN is treated as an illegal instruction, hence cause 2.
  assign cause = take_int                        ? 32'h8000_000B :
                 (ill_instr | (mret & in_run))   ? 32'd2 : 32'd11;

  assign trap_redirect = take_trap | take_mret;
  assign trap_pc       = take_trap ? mtvec_q : mepc_q;
  assign kill          = take_trap;
  assign int_ack       = take_int;
  assign in_handler    = (state_q == HANDLER);

  always_comb begin
    csr_rdata = 32'd0;
    case (csr_addr)
      ADDR_MSTATUS: csr_rdata = {24'd0, mpie_q, 3'd0, mie_q, 3'd0};
      ADDR_MTVEC:   csr_rdata = mtvec_q;
      ADDR_MEPC:    csr_rdata = mepc_q;
      ADDR_MCAUSE:  csr_rdata = mcause_q;
      default:      csr_rdata = 32'd0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    mie_d         = mie_q;
    mpie_d        = mpie_q;
    mtvec_d       = mtvec_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    int_pending_d = int_rise | (int_pending_q & ~take_int);
    if (take_trap) begin
      state_d  = HANDLER;
      mepc_d   = pc_cur & ~32'd3;
      mcause_d = cause;
      mpie_d   = mie_q;
      mie_d    = 1'b0;
    end else if (take_mret) begin
      state_d = RUN;
      mie_d   = mpie_q;
      mpie_d  = 1'b1;
    end else if (csr_wr) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mie_d  = csr_wdata[3];
          mpie_d = csr_wdata[7];
        end
        ADDR_MTVEC:  mtvec_d  = csr_wdata & ~32'd3;
        ADDR_MEPC:   mepc_d   = csr_wdata & ~32'd3;
        ADDR_MCAUSE: mcause_d = csr_wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      sync_prev_q   <= 1'b0;
      int_pending_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], ext_int};
      sync_prev_q   <= sync_q[SYNC_STAGES-1];
      int_pending_q <= int_pending_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      mie_q    <= 1'b0;
      mpie_q   <= 1'b0;
      mtvec_q  <= MTVEC_RESET;
      mepc_q   <= 32'd0;
      mcause_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      mie_q    <= mie_d;
      mpie_q   <= mpie_d;
      mtvec_q  <= mtvec_d;
      mepc_q   <= mepc_d;
      mcause_q <= mcause_d;
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios with literal expectations, then random
// stimulus compared every cycle against an event-level model of the trap rules.
module tb_trap_ctrl;
  localparam int          SYNC      = 2;
  localparam logic [31:0] MTVEC_RST = 32'h0000_0008;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        step = 1'b0, ill_instr = 1'b0, ecall = 1'b0, mret = 1'b0;
  logic        ext_int = 1'b0, csr_we = 1'b0;
  logic [31:0] pc_cur = 32'd0, csr_wdata = 32'd0;
  logic [11:0] csr_addr = 12'h300;
  logic [31:0] csr_rdata, trap_pc;
  logic        trap_redirect, kill, int_ack, in_handler;

  int n_tests = 0;
  int n_fail  = 0;

  trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .step(step), .pc_cur(pc_cur),
    .ill_instr(ill_instr), .ecall(ecall), .mret(mret), .ext_int(ext_int),
    .csr_we(csr_we), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .trap_redirect(trap_redirect), .trap_pc(trap_pc),
    .kill(kill), .int_ack(int_ack), .in_handler(in_handler)
  );

  // clock / reset
  always #5 clk = ~clk;

  // reference model state
  logic        m_mie, m_mpie, m_hand, m_pend;
  logic [31:0] m_mtvec, m_mepc, m_mcause;
  bit          m_hist [SYNC+1];  // m_hist[k]: ext_int sampled k+1 edges ago

  // 0 none, 1 interrupt, 2 illegal/mret-in-RUN, 3 ecall, 4 mret return
  function automatic int m_event();
    if (!rst_n || !step)                 return 0;
    if (m_pend && m_mie && !m_hand)      return 1;
    if (ill_instr || (mret && !m_hand))  return 2;
    if (ecall)                           return 3;
    if (mret)                            return 4;
    return 0;
  endfunction

  function automatic logic [31:0] m_read(logic [11:0] a);
    case (a)
      12'h300: return {24'd0, m_mpie, 3'd0, m_mie, 3'd0};
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int ev;
    if (!rst_n) begin
      m_mie <= 1'b0; m_mpie <= 1'b0; m_hand <= 1'b0; m_pend <= 1'b0;
      m_mtvec <= MTVEC_RST; m_mepc <= 32'd0; m_mcause <= 32'd0;
      for (int i = 0; i <= SYNC; i++) m_hist[i] <= 1'b0;
    end else begin
      ev = m_event();
      m_hist[0] <= ext_int;
      for (int i = 1; i <= SYNC; i++) m_hist[i] <= m_hist[i-1];
      m_pend <= (m_hist[SYNC-1] && !m_hist[SYNC]) || (m_pend && ev != 1);
      if (ev >= 1 && ev <= 3) begin
        m_mepc   <= {pc_cur[31:2], 2'b00};
        m_mcause <= (ev == 1) ? 32'h8000_000B : (ev == 2) ? 32'd2 : 32'd11;
        m_mpie   <= m_mie;
        m_mie    <= 1'b0;
        m_hand   <= 1'b1;
      end else if (ev == 4) begin
        m_mie  <= m_mpie;
        m_mpie <= 1'b1;
        m_hand <= 1'b0;
      end else if (step && csr_we) begin
        case (csr_addr)
          12'h300: begin m_mie <= csr_wdata[3]; m_mpie <= csr_wdata[7]; end
          12'h305: m_mtvec  <= {csr_wdata[31:2], 2'b00};
          12'h341: m_mepc   <= {csr_wdata[31:2], 2'b00};
          12'h342: m_mcause <= csr_wdata;
          default: ;
        endcase
      end
    end
  end

  // scoreboard check
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // compare process
  always @(negedge clk) begin
    int ev;
    ev = m_event();
    chk("redirect", {31'd0, trap_redirect}, {31'd0, ev != 0});
    chk("kill", {31'd0, kill}, {31'd0, ev >= 1 && ev <= 3});
    chk("int_ack", {31'd0, int_ack}, {31'd0, ev == 1});
    chk("in_handler", {31'd0, in_handler}, {31'd0, m_hand});
    chk("csr_rdata", csr_rdata, m_read(csr_addr));
    if (ev != 0) chk("trap_pc", trap_pc, (ev == 4) ? m_mepc : m_mtvec);
  end

  // driver tasks
  task automatic set_in(input bit s, input bit il, input bit ec, input bit mr,
                        input logic [31:0] pc, input bit we = 1'b0,
                        input logic [11:0] a = 12'h300, input logic [31:0] wd = 32'd0);
    step = s; ill_instr = il; ecall = ec; mret = mr; pc_cur = pc;
    csr_we = we; csr_addr = a; csr_wdata = wd;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    set_in(0, 0, 0, 0, 32'd0, 0, 12'h305);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mtvec", csr_rdata, 32'h8);
    chk("rst_in_handler", {31'd0, in_handler}, 32'd0);
    rst_n = 1'b1;
    adv();

    // illegal instruction
    set_in(1, 1, 0, 0, 32'h40);
    #2;
    chk("ill_redirect", {31'd0, trap_redirect}, 32'd1);
    chk("ill_trap_pc", trap_pc, 32'h8);
    chk("ill_kill", {31'd0, kill}, 32'd1);
    adv();
    set_in(0, 0, 0, 0, 32'd0, 0, 12'h341);
    #1 chk("ill_mepc", csr_rdata, 32'h40);
    csr_addr = 12'h342;
    #1 chk("ill_mcause", csr_rdata, 32'd2);
    chk("ill_in_handler", {31'd0, in_handler}, 32'd1);
    set_in(1, 0, 0, 1, 32'h80);
    adv();

    // ecall and return
    set_in(1, 0, 0, 0, 32'h10, 1, 12'h305, 32'h100);
    adv();
    set_in(1, 0, 1, 0, 32'h20);
    #2 chk("ecall_trap_pc", trap_pc, 32'h100);
    adv();
    set_in(0, 0, 0, 0, 32'd0, 0, 12'h342);
    #1 chk("ecall_mcause", csr_rdata, 32'd11);
    csr_addr = 12'h341;
    #1 chk("ecall_mepc", csr_rdata, 32'h20);
    set_in(1, 0, 0, 1, 32'h24);
    #2;
    chk("mret_trap_pc", trap_pc, 32'h20);
    chk("mret_kill", {31'd0, kill}, 32'd0);
    chk("mret_redirect", {31'd0, trap_redirect}, 32'd1);
    adv();
    chk("mret_in_handler", {31'd0, in_handler}, 32'd0);

    // interrupt
    set_in(1, 0, 0, 0, 32'h30, 1, 12'h300, 32'h8);
    adv();
    set_in(0, 0, 0, 0, 32'd0);
    ext_int = 1'b1;
    adv(); adv();
    ext_int = 1'b0;
    adv();
    set_in(1, 0, 0, 0, 32'h60);
    #2;
    chk("int_ack", {31'd0, int_ack}, 32'd1);
    chk("int_trap_pc", trap_pc, 32'h100);
    adv();
    set_in(0, 0, 0, 0, 32'd0, 0, 12'h342);
    #1 chk("int_mcause", csr_rdata, 32'h8000_000B);
    csr_addr = 12'h341;
    #1 chk("int_mepc", csr_rdata, 32'h60);
    csr_addr = 12'h300;
    #1 chk("int_mstatus", csr_rdata, 32'h80);
    set_in(1, 0, 0, 1, 32'h104);
    adv();
    set_in(0, 0, 0, 0, 32'd0);
    #1 chk("mret_mstatus", csr_rdata, 32'h88);

    // masked interrupt, then enable by mstatus write
    set_in(1, 0, 0, 0, 32'h30, 1, 12'h300, 32'h0);
    adv();
    ext_int = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(1, 0, 0, 0, 32'h200 + 32'(4 * i));
      #2 chk("masked_no_trap", {31'd0, trap_redirect}, 32'd0);
      adv();
    end
    set_in(1, 0, 0, 0, 32'h300, 1, 12'h300, 32'h8);
    #2 chk("mie_write_no_trap", {31'd0, trap_redirect}, 32'd0);
    adv();
    set_in(1, 0, 0, 0, 32'h90);
    #2 chk("mie_next_int_ack", {31'd0, int_ack}, 32'd1);
    adv();
    set_in(1, 0, 0, 1, 32'h104);
    ext_int = 1'b0;
    adv();

    // priority and collisions
    set_in(1, 1, 1, 0, 32'h70);
    adv();
    set_in(0, 0, 0, 0, 32'd0, 0, 12'h342);
    #1 chk("ill_ecall_mcause", csr_rdata, 32'd2);
    set_in(1, 0, 0, 1, 32'h104);
    adv();
    set_in(1, 0, 0, 1, 32'h74);
    #2;
    chk("mret_run_kill", {31'd0, kill}, 32'd1);
    chk("mret_run_trap_pc", trap_pc, 32'h100);
    adv();
    set_in(0, 0, 0, 0, 32'd0, 0, 12'h342);
    #1 chk("mret_run_mcause", csr_rdata, 32'd2);
    chk("mret_run_in_handler", {31'd0, in_handler}, 32'd1);
    set_in(1, 0, 0, 1, 32'h104);
    adv();
    set_in(1, 0, 1, 0, 32'h78, 1, 12'h305, 32'h200);
    adv();
    set_in(0, 0, 0, 0, 32'd0, 0, 12'h305);
    #1 chk("collide_mtvec", csr_rdata, 32'h100);
    set_in(1, 0, 0, 1, 32'h104);
    adv();

    // stall and reset
    set_in(0, 0, 1, 0, 32'h7c);
    #2 chk("stall_redirect", {31'd0, trap_redirect}, 32'd0);
    adv();
    chk("stall_in_handler", {31'd0, in_handler}, 32'd0);
    set_in(1, 0, 1, 0, 32'h80);
    adv();
    set_in(1, 1, 0, 0, 32'h84, 0, 12'h341);
    #1 chk("pre_rst_in_handler", {31'd0, in_handler}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_in_handler", {31'd0, in_handler}, 32'd0);
    chk("rst_mid_redirect", {31'd0, trap_redirect}, 32'd0);
    chk("rst_mid_mepc", csr_rdata, 32'd0);
    csr_addr = 12'h305;
    #1 chk("rst_mid_mtvec", csr_rdata, 32'h8);
    adv();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 32'd0);
    adv();

    // random phase, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      logic [11:0] addrs [6];
      addrs[0] = 12'h300; addrs[1] = 12'h305; addrs[2] = 12'h341;
      addrs[3] = 12'h342; addrs[4] = 12'h300; addrs[5] = 12'($urandom);
      set_in($urandom_range(0, 9) < 8,
             $urandom_range(0, 19) == 0,
             $urandom_range(0, 14) == 0,
             in_handler ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0),
             $urandom,
             $urandom_range(0, 4) == 0,
             addrs[$urandom_range(0, 5)],
             $urandom);
      if ($urandom_range(0, 7) == 0) ext_int = ~ext_int;
      adv();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
